// File: rtl/div_pkg.sv
// Shared types, constant test vectors and expected results for the divider initiator.
package div_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitDone,
    StAck,
    StWaitLow,
    StFinish
  } div_state_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } div_operands_t;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
  } div_result_t;

  localparam int unsigned MaxTests       = 4;
  localparam int unsigned DefaultTimeout = 40;

  function automatic div_operands_t vec_operands(logic [1:0] idx);
    case (idx)
      2'd0:    return '{x: 4'd15, y: 4'd2};
      2'd1:    return '{x: 4'd5,  y: 4'd8};
      2'd2:    return '{x: 4'd11, y: 4'd3};
      default: return '{x: 4'd15, y: 4'd1};
    endcase
  endfunction

  function automatic div_result_t vec_expected(logic [1:0] idx);
    case (idx)
      2'd0:    return '{q: 4'd7,  r: 4'd1};
      2'd1:    return '{q: 4'd0,  r: 4'd5};
      2'd2:    return '{q: 4'd3,  r: 4'd2};
      default: return '{q: 4'd15, r: 4'd0};
    endcase
  endfunction

  function automatic logic [2:0] sat_inc(logic [2:0] val);
    return (val == 3'd7) ? val : val + 3'd1;
  endfunction

endpackage

// File: rtl/div_result_checker.sv
// Compares the registered divider result with the expected entry; pulses on mismatch.
module div_result_checker
  import div_pkg::*;
(
  input  logic        check_i,
  input  div_result_t actual_i,
  input  div_result_t expected_i,
  output logic        mismatch_o
);

  assign mismatch_o = check_i && (actual_i != expected_i);

endmodule

// File: rtl/div_initiator.sv
// Drives the constant vector table into an external divider and counts bad results/timeouts.
module div_initiator
  import div_pkg::*;
#(
  parameter int unsigned NUM_TESTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Go,
  input  logic       Done,
  input  logic [3:0] Quotient,
  input  logic [3:0] Remainder,
  output logic [3:0] Xin,
  output logic [3:0] Yin,
  output logic       Start,
  output logic       Ack,
  output logic       Busy,
  output logic       Finished,
  output logic [2:0] ErrCnt,
  output logic [1:0] TestIdx,
  output logic       TimedOut
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]      LastIdx = 2'(NUM_TESTS - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  div_state_e      state_q;
  logic [TmoW-1:0] tmo_cnt_q;
  div_result_t     result_q;
  div_operands_t   opnd_q;
  logic            start_q, ack_q, busy_q, finished_q, timed_out_q;
  logic [2:0]      err_cnt_q;
  logic [1:0]      test_idx_q;
  logic            mismatch;

  div_result_checker u_checker (
    .check_i    (state_q == StAck),
    .actual_i   (result_q),
    .expected_i (vec_expected(test_idx_q)),
    .mismatch_o (mismatch)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      result_q    <= '0;
      opnd_q      <= '0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
      err_cnt_q   <= '0;
      test_idx_q  <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      unique case (state_q)
        StIdle, StFinish: begin
          if (Go) begin
            err_cnt_q   <= '0;
            timed_out_q <= 1'b0;
            test_idx_q  <= '0;
            opnd_q      <= vec_operands(2'd0);
            busy_q      <= 1'b1;
            finished_q  <= 1'b0;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          start_q <= 1'b1;
          state_q <= StStart;
        end
        StStart: begin
          tmo_cnt_q <= '0;
          state_q   <= StWaitDone;
        end
        StWaitDone: begin
          if (Done) begin
            result_q <= '{q: Quotient, r: Remainder};
            ack_q    <= 1'b1;
            state_q  <= StAck;
          end else if (tmo_cnt_q == TmoLast) begin
            timed_out_q <= 1'b1;
            err_cnt_q   <= sat_inc(err_cnt_q);
            busy_q      <= 1'b0;
            finished_q  <= 1'b1;
            state_q     <= StFinish;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StAck: begin
          if (mismatch) err_cnt_q <= sat_inc(err_cnt_q);
          tmo_cnt_q <= '0;
          state_q   <= StWaitLow;
        end
        StWaitLow: begin
          // Operands must not change until the divider has released Done.
          if (!Done) begin
            if (test_idx_q == LastIdx) begin
              busy_q     <= 1'b0;
              finished_q <= 1'b1;
              state_q    <= StFinish;
            end else begin
              test_idx_q <= test_idx_q + 2'd1;
              opnd_q     <= vec_operands(test_idx_q + 2'd1);
              state_q    <= StLoad;
            end
          end else if (tmo_cnt_q == TmoLast) begin
            timed_out_q <= 1'b1;
            err_cnt_q   <= sat_inc(err_cnt_q);
            busy_q      <= 1'b0;
            finished_q  <= 1'b1;
            state_q     <= StFinish;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Xin      = opnd_q.x;
  assign Yin      = opnd_q.y;
  assign Start    = start_q;
  assign Ack      = ack_q;
  assign Busy     = busy_q;
  assign Finished = finished_q;
  assign ErrCnt   = err_cnt_q;
  assign TestIdx  = test_idx_q;
  assign TimedOut = timed_out_q;

endmodule
